// File: rtl/tlul_adapter_reg_pipe_pkg.sv
// TL-UL channel types and the response-queue entry shared by the register adapter.
package tlul_adapter_reg_pipe_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic parity_en;
  } tl_a_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic              filled;
    tl_d_op_e          opcode;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_DW-1:0]  data;
    logic              err;
  } reg_rsp_entry_t;

endpackage

// File: rtl/tlul_adapter_reg_rspq.sv
// In-order response queue; entries are pushed in request order and filled
// oldest-unfilled-first, so read data may land while older writes wait at the head.
module tlul_adapter_reg_rspq
  import tlul_adapter_reg_pipe_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  reg_rsp_entry_t   push_entry,
  input  logic             pop,
  input  logic             fill,
  input  logic [TL_DW-1:0] fill_data,
  input  logic             fill_err,
  output logic             full,
  output logic             empty,
  output logic             pend,
  output reg_rsp_entry_t   head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  reg_rsp_entry_t  q [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] fill_ptr;
  logic [CntW-1:0] count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-to-fill pointer: first occupied, unfilled slot walking from the head
  always_comb begin
    logic [PtrW-1:0] idx;
    pend     = 1'b0;
    fill_ptr = rd_ptr;
    idx      = rd_ptr;
    for (int i = 0; i < Depth; i++) begin
      if (!pend && (CntW'(i) < count) && !q[idx].filled) begin
        pend     = 1'b1;
        fill_ptr = idx;
      end
      idx = ptr_inc(idx);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Depth; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (push) begin
        q[wr_ptr] <= push_entry;
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (fill) begin
        q[fill_ptr].filled <= 1'b1;
        q[fill_ptr].data   <= fill_data;
        q[fill_ptr].err    <= q[fill_ptr].err | fill_err;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);
  assign head  = q[rd_ptr];

endmodule

// File: rtl/tlul_err.sv
// TL-UL A-channel legality check: opcode, size, address alignment and mask window.
module tlul_err
  import tlul_adapter_reg_pipe_pkg::*;
(
  input  tl_a_op_e          opcode,
  input  logic [TL_SZW-1:0] size,
  input  logic [1:0]        addr_lsb,
  input  logic [TL_DBW-1:0] mask,
  output logic              err
);

  logic [TL_DBW-1:0] win;
  logic              addr_ok;
  logic              op_ok;
  logic              mask_ok;

  always_comb begin
    win     = '0;
    addr_ok = 1'b0;
    case (size)
      2'd0: begin
        win     = TL_DBW'(1) << addr_lsb;
        addr_ok = 1'b1;
      end
      2'd1: begin
        win     = TL_DBW'(3) << addr_lsb;
        addr_ok = ~addr_lsb[0];
      end
      2'd2: begin
        win     = '1;
        addr_ok = (addr_lsb == 2'b00);
      end
      default: ;
    endcase
  end

  assign op_ok   = (opcode == Get) || (opcode == PutFullData) || (opcode == PutPartialData);
  // PutFull must cover exactly the sized window; other opcodes only stay inside it
  assign mask_ok = ((mask & ~win) == '0) && ((opcode != PutFullData) || (mask == win));
  assign err     = ~(op_ok & addr_ok & mask_ok);

endmodule

// File: rtl/tlul_adapter_reg_pipe.sv
// TL-UL device adapter to a register interface with several in-order requests in
// flight and a per-read timeout that turns a hung register read into an error response.
module tlul_adapter_reg_pipe
  import tlul_adapter_reg_pipe_pkg::*;
#(
  parameter int unsigned RegAw          = 8,
  parameter int unsigned RegDw          = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RdTimeout      = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [RegDw-1:0]   wdata_o,
  output logic [RegDw/8-1:0] be_o,
  input  logic [RegDw-1:0]   rdata_i,
  input  logic               rdata_valid_i,
  input  logic               error_i,
  output logic               timeout_o,
  output logic               busy_o
);

  localparam int unsigned TW  = (RdTimeout > 0) ? $clog2(RdTimeout + 1) : 1;
  localparam int unsigned SkW = $clog2(MaxOutstanding + 1);

  if (RegDw != TL_DW) begin : g_dw_check
    $error("RegDw must equal TL_DW");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_depth_check
    $error("MaxOutstanding must be within 1..8");
  end

  logic           a_ack;
  logic           is_get;
  logic           err_tl;
  logic           err_internal;
  logic           q_full;
  logic           q_empty;
  logic           q_pend;
  logic           d_valid;
  logic           pop;
  logic           data_fill;
  logic           to_hit;
  logic           fill;
  reg_rsp_entry_t enq_entry;
  reg_rsp_entry_t head;
  logic [TW-1:0]  to_cnt;
  logic [SkW-1:0] skip_cnt;
  logic           unused_addr;

  tlul_err u_err (
    .opcode   (tl_i.a_opcode),
    .size     (tl_i.a_size),
    .addr_lsb (tl_i.a_address[1:0]),
    .mask     (tl_i.a_mask),
    .err      (err_tl)
  );

  assign a_ack        = tl_i.a_valid & ~q_full;
  assign is_get       = (tl_i.a_opcode == Get);
  assign err_internal = (~is_get & (tl_i.a_address[1:0] != 2'b00))
                      | tl_i.a_user.parity_en | err_tl;

  assign re_o        = a_ack & is_get & ~err_internal;
  assign we_o        = a_ack & ~is_get & ~err_internal;
  assign addr_o      = {tl_i.a_address[RegAw-1:2], 2'b00};
  assign wdata_o     = tl_i.a_data;
  assign be_o        = tl_i.a_mask;
  assign unused_addr = ^tl_i.a_address[TL_AW-1:RegAw];

  always_comb begin
    enq_entry        = '0;
    enq_entry.opcode = is_get ? AccessAckData : AccessAck;
    enq_entry.size   = tl_i.a_size;
    enq_entry.source = tl_i.a_source;
    enq_entry.err    = error_i | err_internal;
    enq_entry.filled = ~is_get | err_internal;
  end

  // Register data always beats a same-cycle timeout; beats owed to timed-out reads are dropped
  assign data_fill = rdata_valid_i & (skip_cnt == '0) & q_pend;
  assign to_hit    = (RdTimeout != 0) && q_pend && !rdata_valid_i
                  && (to_cnt == TW'(RdTimeout - 1));
  assign fill      = data_fill | to_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt   <= '0;
      skip_cnt <= '0;
    end else begin
      if (!q_pend || fill) begin
        to_cnt <= '0;
      end else if (RdTimeout != 0) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (to_hit && (skip_cnt != SkW'(MaxOutstanding))) begin
        skip_cnt <= skip_cnt + SkW'(1);
      end else if (rdata_valid_i && (skip_cnt != '0)) begin
        skip_cnt <= skip_cnt - SkW'(1);
      end
    end
  end

  tlul_adapter_reg_rspq #(
    .Depth (MaxOutstanding)
  ) u_rspq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (a_ack),
    .push_entry (enq_entry),
    .pop        (pop),
    .fill       (fill),
    .fill_data  (to_hit ? '0 : rdata_i),
    .fill_err   (to_hit),
    .full       (q_full),
    .empty      (q_empty),
    .pend       (q_pend),
    .head       (head)
  );

  assign d_valid = ~q_empty & head.filled;
  assign pop     = d_valid & tl_i.d_ready;

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = ~q_full;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head.opcode;
    tl_o.d_size   = head.size;
    tl_o.d_source = head.source;
    tl_o.d_data   = head.data;
    tl_o.d_error  = head.err;
  end

  assign timeout_o = to_hit;
  assign busy_o    = ~q_empty;

  a_no_orphan_rdata: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rdata_valid_i |-> (q_pend || (skip_cnt != '0)));

endmodule

// File: tb/tb_tlul_adapter_reg_pipe.sv
// Directed bench for tlul_adapter_reg_pipe: a depth-1 instance for legacy timing and a
// depth-2 instance with an 8-cycle read timeout, selected by sel1.
module tb_tlul_adapter_reg_pipe;
  import tlul_adapter_reg_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel1;
  tl_h2d_t     tl_i, tl_i_1, tl_i_2;
  tl_d2h_t     tl_o, tl_o_1, tl_o_2;
  logic [31:0] rdata;
  logic        rdv, err_in;
  logic        re_1, we_1, to_1, busy_1, re_2, we_2, to_2, busy_2;
  logic [7:0]  addr_1, addr_2;
  logic [31:0] wdata_1, wdata_2;
  logic [3:0]  be_1, be_2;
  logic        re, we, tout, busy;
  logic [7:0]  addr;
  logic [31:0] wdata;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    tl_i_1         = tl_i;
    tl_i_1.a_valid = tl_i.a_valid & sel1;
    tl_i_2         = tl_i;
    tl_i_2.a_valid = tl_i.a_valid & ~sel1;
  end

  tlul_adapter_reg_pipe #(.RegAw(8), .RegDw(32), .MaxOutstanding(1), .RdTimeout(255)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i_1), .tl_o(tl_o_1), .re_o(re_1), .we_o(we_1),
    .addr_o(addr_1), .wdata_o(wdata_1), .be_o(be_1), .rdata_i(rdata), .rdata_valid_i(rdv & sel1),
    .error_i(err_in), .timeout_o(to_1), .busy_o(busy_1));

  tlul_adapter_reg_pipe #(.RegAw(8), .RegDw(32), .MaxOutstanding(2), .RdTimeout(8)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_i_2), .tl_o(tl_o_2), .re_o(re_2), .we_o(we_2),
    .addr_o(addr_2), .wdata_o(wdata_2), .be_o(be_2), .rdata_i(rdata), .rdata_valid_i(rdv & ~sel1),
    .error_i(err_in), .timeout_o(to_2), .busy_o(busy_2));

  assign tl_o  = sel1 ? tl_o_1  : tl_o_2;
  assign re    = sel1 ? re_1    : re_2;
  assign we    = sel1 ? we_1    : we_2;
  assign addr  = sel1 ? addr_1  : addr_2;
  assign wdata = sel1 ? wdata_1 : wdata_2;
  assign tout  = sel1 ? to_1    : to_2;
  assign busy  = sel1 ? busy_1  : busy_2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input tl_a_op_e op, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] src, input logic par);
    tl_i.a_valid            = 1'b1;
    tl_i.a_opcode           = op;
    tl_i.a_size             = 2'd2;
    tl_i.a_address          = a;
    tl_i.a_data             = d;
    tl_i.a_mask             = 4'hF;
    tl_i.a_source           = src;
    tl_i.a_user.parity_en   = par;
  endtask

  task automatic idle_a();
    tl_i.a_valid = 1'b0;
    tl_i.a_user.parity_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel1 = 1'b0; tl_i = '0; rdata = '0; rdv = 1'b0; err_in = 1'b0;

    // reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_a_ready", tl_o.a_ready, 1); chk("rst_d_valid", tl_o.d_valid, 0);
    chk("rst_d_data", tl_o.d_data, 0);   chk("rst_d_error", tl_o.d_error, 0);
    chk("rst_d_opcode", tl_o.d_opcode, AccessAck);
    chk("rst_timeout", tout, 0);         chk("rst_busy", busy, 0);
    tick(); rst_n = 1'b1;

    // 1: depth-1 Put
    tick(); sel1 = 1'b1; tl_i.d_ready = 1'b0;
    req(PutFullData, 32'h10, 32'hA5A5A5A5, 8'd3, 1'b0);
    @(negedge clk);
    chk("t1_we", we, 1); chk("t1_re", re, 0); chk("t1_addr", addr, 8'h10);
    chk("t1_wdata", wdata, 32'hA5A5A5A5); chk("t1_d_valid0", tl_o.d_valid, 0);
    tick(); idle_a();
    @(negedge clk);
    chk("t1_we_off", we, 0); chk("t1_d_valid", tl_o.d_valid, 1);
    chk("t1_opcode", tl_o.d_opcode, AccessAck); chk("t1_source", tl_o.d_source, 3);
    chk("t1_error", tl_o.d_error, 0); chk("t1_a_ready_full", tl_o.a_ready, 0); chk("t1_busy", busy, 1);
    tick(); tl_i.d_ready = 1'b1;
    @(negedge clk);
    chk("t1_no_bypass", tl_o.a_ready, 0);
    tick(); tl_i.d_ready = 1'b0;
    @(negedge clk);
    chk("t1_a_ready_back", tl_o.a_ready, 1); chk("t1_d_valid_off", tl_o.d_valid, 0); chk("t1_busy_off", busy, 0);

    // 2: two back-to-back Gets
    tick(); sel1 = 1'b0; tl_i.d_ready = 1'b1;
    req(Get, 32'h04, 32'h0, 8'd5, 1'b0);
    @(negedge clk); chk("t2_re0", re, 1); chk("t2_addr0", addr, 8'h04);
    tick(); req(Get, 32'h08, 32'h0, 8'd6, 1'b0);
    @(negedge clk); chk("t2_re1", re, 1); chk("t2_addr1", addr, 8'h08); chk("t2_a_ready1", tl_o.a_ready, 1);
    tick(); idle_a();
    @(negedge clk); chk("t2_full", tl_o.a_ready, 0);
    tick(); rdv = 1'b1; rdata = 32'h11;
    @(negedge clk); chk("t2_dv_c3", tl_o.d_valid, 0);
    tick(); rdv = 1'b0;
    @(negedge clk);
    chk("t2_dv_a", tl_o.d_valid, 1); chk("t2_data_a", tl_o.d_data, 32'h11);
    chk("t2_op_a", tl_o.d_opcode, AccessAckData); chk("t2_src_a", tl_o.d_source, 5);
    tick(); rdv = 1'b1; rdata = 32'h22;
    @(negedge clk); chk("t2_dv_c5", tl_o.d_valid, 0);
    tick(); rdv = 1'b0;
    @(negedge clk);
    chk("t2_dv_b", tl_o.d_valid, 1); chk("t2_data_b", tl_o.d_data, 32'h22); chk("t2_src_b", tl_o.d_source, 6);
    tick();
    @(negedge clk); chk("t2_busy_off", busy, 0);

    // 3: back-pressure on D, third request stalls
    tick(); tl_i.d_ready = 1'b0;
    req(Get, 32'h0C, 32'h0, 8'd1, 1'b0);
    @(negedge clk); chk("t3_re0", re, 1);
    tick(); req(Get, 32'h10, 32'h0, 8'd2, 1'b0);
    @(negedge clk); chk("t3_re1", re, 1);
    tick(); req(Get, 32'h14, 32'h0, 8'd7, 1'b0); rdv = 1'b1; rdata = 32'hDEAD0001;
    @(negedge clk); chk("t3_stall_a_ready", tl_o.a_ready, 0); chk("t3_stall_re", re, 0);
    tick(); rdata = 32'hDEAD0002;
    @(negedge clk); chk("t3_dv", tl_o.d_valid, 1); chk("t3_data", tl_o.d_data, 32'hDEAD0001);
    chk("t3_src", tl_o.d_source, 1);
    tick(); rdv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", tl_o.d_valid, 1); chk("t3_hold_data", tl_o.d_data, 32'hDEAD0001);
      chk("t3_hold_stall", tl_o.a_ready, 0);
      tick();
    end
    tl_i.d_ready = 1'b1;
    @(negedge clk); chk("t3_pop_a_ready", tl_o.a_ready, 0);
    tick();
    @(negedge clk);
    chk("t3_accept3", re, 1); chk("t3_addr3", addr, 8'h14);
    chk("t3_dv2", tl_o.d_valid, 1); chk("t3_data2", tl_o.d_data, 32'hDEAD0002); chk("t3_src2", tl_o.d_source, 2);
    tick(); idle_a(); rdv = 1'b1; rdata = 32'h55;
    @(negedge clk); chk("t3_dv3_wait", tl_o.d_valid, 0); chk("t3_busy3", busy, 1);
    tick(); rdv = 1'b0;
    @(negedge clk);
    chk("t3_dv3", tl_o.d_valid, 1); chk("t3_data3", tl_o.d_data, 32'h55); chk("t3_src3", tl_o.d_source, 7);
    tick();
    @(negedge clk); chk("t3_busy_off", busy, 0);

    // 4: read timeout after 8 cycles, late beat discarded
    tick(); req(Get, 32'h20, 32'h0, 8'd9, 1'b0);
    @(negedge clk); chk("t4_re", re, 1);
    tick(); idle_a();
    @(negedge clk); chk("t4_no_to_1", tout, 0);
    for (int k = 2; k < 8; k++) begin
      tick();
      @(negedge clk); chk("t4_no_to", tout, 0); chk("t4_no_dv", tl_o.d_valid, 0);
    end
    tick();
    @(negedge clk); chk("t4_timeout", tout, 1); chk("t4_dv_pre", tl_o.d_valid, 0);
    tick();
    @(negedge clk);
    chk("t4_to_pulse", tout, 0); chk("t4_dv", tl_o.d_valid, 1); chk("t4_err", tl_o.d_error, 1);
    chk("t4_data0", tl_o.d_data, 0); chk("t4_op", tl_o.d_opcode, AccessAckData); chk("t4_src", tl_o.d_source, 9);
    tick(); req(Get, 32'h24, 32'h0, 8'd10, 1'b0);
    @(negedge clk); chk("t4_re2", re, 1); chk("t4_busy_gap", busy, 0);
    tick(); idle_a(); rdv = 1'b1; rdata = 32'h33;
    @(negedge clk); chk("t4_late_dv", tl_o.d_valid, 0);
    tick(); rdata = 32'h44;
    @(negedge clk); chk("t4_skip_dv", tl_o.d_valid, 0);
    tick(); rdv = 1'b0;
    @(negedge clk);
    chk("t4_dv2", tl_o.d_valid, 1); chk("t4_data2", tl_o.d_data, 32'h44);
    chk("t4_err2", tl_o.d_error, 0); chk("t4_src2", tl_o.d_source, 10);
    tick();
    @(negedge clk); chk("t4_busy_off", busy, 0);

    // 5: internal errors suppress strobes; register-side error keeps strobe
    tick(); req(PutFullData, 32'h02, 32'h1, 8'd4, 1'b0);
    @(negedge clk); chk("t5_we_mis", we, 0); chk("t5_re_mis", re, 0);
    tick(); req(Get, 32'h04, 32'h0, 8'd8, 1'b1);
    @(negedge clk);
    chk("t5_re_par", re, 0); chk("t5_dv_mis", tl_o.d_valid, 1);
    chk("t5_op_mis", tl_o.d_opcode, AccessAck); chk("t5_err_mis", tl_o.d_error, 1);
    tick(); req(PutFullData, 32'h08, 32'h2, 8'd11, 1'b0); err_in = 1'b1;
    @(negedge clk);
    chk("t5_we_errin", we, 1); chk("t5_dv_par", tl_o.d_valid, 1); chk("t5_op_par", tl_o.d_opcode, AccessAckData);
    chk("t5_err_par", tl_o.d_error, 1); chk("t5_data_par", tl_o.d_data, 0); chk("t5_src_par", tl_o.d_source, 8);
    tick(); idle_a(); err_in = 1'b0;
    @(negedge clk);
    chk("t5_dv_errin", tl_o.d_valid, 1); chk("t5_err_errin", tl_o.d_error, 1); chk("t5_src_errin", tl_o.d_source, 11);
    tick();
    @(negedge clk); chk("t5_busy_off", busy, 0);

    // 6: reset with two reads queued
    tick(); tl_i.d_ready = 1'b0; req(Get, 32'h04, 32'h0, 8'd1, 1'b0);
    tick(); req(Get, 32'h08, 32'h0, 8'd2, 1'b0);
    tick(); idle_a(); rdv = 1'b1; rdata = 32'h66;
    tick(); rdv = 1'b0;
    @(negedge clk); chk("t6_dv_pre", tl_o.d_valid, 1); chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; tl_i.d_ready = 1'b1; req(PutFullData, 32'h0C, 32'h12345678, 8'd3, 1'b0);
    @(negedge clk);
    chk("t6_dv_rst", tl_o.d_valid, 0); chk("t6_busy_rst", busy, 0); chk("t6_a_ready_rst", tl_o.a_ready, 1);
    chk("t6_we", we, 1); chk("t6_wdata", wdata, 32'h12345678);
    tick(); idle_a();
    @(negedge clk);
    chk("t6_dv", tl_o.d_valid, 1); chk("t6_op", tl_o.d_opcode, AccessAck);
    chk("t6_err", tl_o.d_error, 0); chk("t6_src", tl_o.d_source, 3);
    tick();
    @(negedge clk); chk("t6_busy_off", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
